pdp_mem_responder: RTL and testbench

- Memory-side responder for the PDP-11 pipeline: serves instruction-fetch reads and data reads/writes (operand fetch, write-back) from one single-ported 16-bit word store.
- Two independent valid/ready request/response channels (fetch, data) share one FSM with round-robin arbitration, programmable wait states, and PDP-11 odd-address / out-of-range bus errors.

---
 rtl/pdp_mem_responder.sv | 169 ++++++++++++++++
 tb/tb_pdp_mem_responder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp_mem_responder.sv
// pdp_mem_responder: memory-side responder for the PDP-11 pipeline.
// One single-ported store of DEPTH_WORDS 16-bit words. It serves an
// instruction-fetch channel and a data channel, one transaction at a time.
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   if_req_* / if_rsp_*          : fetch channel (word reads only)
//   d_req_* / d_rsp_*            : data channel (word/byte reads and writes)
// Each transaction goes IDLE -> WAIT (WAIT_STATES cycles) -> RESP -> IDLE.
// When both channels request together they alternate (round robin).
// Odd word addresses and out-of-range addresses return err=1 and data=0.
module pdp_mem_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [15:0] if_req_addr,
  output logic        if_rsp_valid,
  input  logic        if_rsp_ready,
  output logic [15:0] if_rsp_data,
  output logic        if_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [15:0] d_req_addr,
  input  logic        d_req_we,
  input  logic        d_req_byte,
  input  logic [15:0] d_req_wdata,
  output logic        d_rsp_valid,
  input  logic        d_rsp_ready,
  output logic [15:0] d_rsp_data,
  output logic        d_rsp_err
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CW-1:0] WLAST = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;
  localparam logic CH_F = 1'b0;
  localparam logic CH_D = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic        owner;
    logic [15:0] addr;
    logic        we;
    logic        bsel;
    logic [15:0] wdata;
  } req_t;

  state_t        state, state_n;
  req_t          lat, new_req, acc;
  logic          last_grant;
  logic [CW-1:0] wcnt;
  logic [15:0]   rsp_data, rd_word, rdata_n;
  logic          rsp_err;
  logic [15:0]   mem [DEPTH_WORDS];
  logic          pick_d, pick_f, accept, enter_resp, rsp_fire, oor, bad;
  logic [14:0]   widx;
  logic [AW-1:0] midx;

  // Round robin: with both valid, the channel that did not win last time wins.
  assign pick_d = d_req_valid && (!if_req_valid || last_grant == CH_F);
  assign pick_f = if_req_valid && !pick_d;
  assign accept = (state == S_IDLE) && !reset && (pick_d || pick_f);

  always_comb begin
    new_req       = '0;
    new_req.owner = pick_d ? CH_D : CH_F;
    new_req.addr  = pick_d ? d_req_addr : if_req_addr;
    new_req.we    = pick_d && d_req_we;
    new_req.bsel  = pick_d && d_req_byte;
    new_req.wdata = d_req_wdata;
  end

  // With zero wait states the access happens on the acceptance edge, so the
  // incoming request is used directly; otherwise the latched copy is used.
  assign acc        = (state == S_IDLE) ? new_req : lat;
  assign enter_resp = (accept && WAIT_STATES == 0) || (state == S_WAIT && wcnt == WLAST);
  assign rsp_fire   = (state == S_RESP) && ((lat.owner == CH_D) ? d_rsp_ready : if_rsp_ready);

  // Range is checked first; an odd word address is the second trap source.
  assign widx    = acc.addr[15:1];
  assign midx    = widx[AW-1:0];
  assign oor     = {17'd0, widx} >= 32'(DEPTH_WORDS);
  assign bad     = oor || (!acc.bsel && acc.addr[0]);
  assign rd_word = mem[midx];

  always_comb begin
    rdata_n = '0;
    if (!bad && !acc.we)
      rdata_n = acc.bsel ? {8'h00, (acc.addr[0] ? rd_word[15:8] : rd_word[7:0])} : rd_word;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (wcnt == WLAST) state_n = S_RESP;
      S_RESP:  if (rsp_fire) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs: response fields read as zero whenever their valid is low.
  always_comb begin
    if_req_ready = 1'b0;
    d_req_ready  = 1'b0;
    if_rsp_valid = 1'b0;
    if_rsp_data  = '0;
    if_rsp_err   = 1'b0;
    d_rsp_valid  = 1'b0;
    d_rsp_data   = '0;
    d_rsp_err    = 1'b0;
    if (state == S_IDLE && !reset) begin
      if_req_ready = pick_f;
      d_req_ready  = pick_d;
    end
    if (state == S_RESP) begin
      if (lat.owner == CH_D) begin
        d_rsp_valid = 1'b1;
        d_rsp_data  = rsp_data;
        d_rsp_err   = rsp_err;
      end else begin
        if_rsp_valid = 1'b1;
        if_rsp_data  = rsp_data;
        if_rsp_err   = rsp_err;
      end
    end
  end

  // Transaction latch, wait counter, response registers
  always_ff @(posedge clock) begin
    if (reset) begin
      lat        <= '0;
      last_grant <= CH_F;
      wcnt       <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        lat        <= new_req;
        last_grant <= new_req.owner;
        wcnt       <= '0;
      end else if (state == S_WAIT) begin
        wcnt <= wcnt + CW'(1);
      end
      if (enter_resp) begin
        rsp_data <= rdata_n;
        rsp_err  <= bad;
      end
    end
  end

  // Store: written once per transaction, on the edge entering RESP.
  always_ff @(posedge clock) begin
    if (!reset && enter_resp && !bad && acc.we) begin
      if (!acc.bsel)        mem[midx]       <= acc.wdata;
      else if (acc.addr[0]) mem[midx][15:8] <= acc.wdata[7:0];
      else                  mem[midx][7:0]  <= acc.wdata[7:0];
    end
  end
endmodule

// File: tb/tb_pdp_mem_responder.sv
// Bench for pdp_mem_responder: directed scenarios with literal expectations
// plus a randomized phase, all shadowed by a transaction-level model that is
// compared against the DUT outputs on every falling edge.
module tb_pdp_mem_responder;
  localparam int DEPTH = 4096;
  localparam int WS    = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err;
  logic [15:0] if_req_addr, if_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we, d_req_byte, d_rsp_valid, d_rsp_ready, d_rsp_err;
  logic [15:0] d_req_addr, d_req_wdata, d_rsp_data;

  pdp_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
    .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_byte(d_req_byte), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
    .d_rsp_err(d_rsp_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [15:0] mmem   [DEPTH];
  bit          mknown [DEPTH];
  bit          m_live = 0;
  bit          m_busy = 0, m_resp = 0, m_owner = 0, m_last = 0;  // owner/last: 1 = data
  int          m_left = 0;
  logic [15:0] m_addr, m_wdata, m_data;
  bit          m_we, m_bsel, m_err, m_dknown;

  function automatic bit grant_d();
    return d_req_valid && (!if_req_valid || !m_last);
  endfunction

  function automatic bit grant_f();
    return if_req_valid && !grant_d();
  endfunction

  // Perform the memory effect of the pending transaction.
  task automatic m_access();
    int idx;
    idx      = int'(m_addr) / 2;
    m_data   = 16'h0000;
    m_err    = 0;
    m_dknown = 1;
    if (idx >= DEPTH || (!m_bsel && (m_addr % 2 == 1))) m_err = 1;
    else if (m_we) begin
      if (!m_bsel) begin mmem[idx] = m_wdata; mknown[idx] = 1; end
      else if (m_addr % 2 == 1) mmem[idx] = {m_wdata[7:0], mmem[idx][7:0]};
      else mmem[idx] = {mmem[idx][15:8], m_wdata[7:0]};
    end else begin
      m_dknown = mknown[idx];
      if (!m_bsel) m_data = mmem[idx];
      else m_data = (m_addr % 2 == 1) ? (mmem[idx] >> 8) : (mmem[idx] & 16'h00FF);
    end
  endtask

  task automatic m_compare();
    bit fv, dv, idle;
    idle = !m_busy;
    fv   = m_busy && m_resp && !m_owner;
    dv   = m_busy && m_resp && m_owner;
    chk("if_req_ready", if_req_ready, !reset && idle && grant_f());
    chk("d_req_ready",  d_req_ready,  !reset && idle && grant_d());
    chk("if_rsp_valid", if_rsp_valid, fv);
    chk("d_rsp_valid",  d_rsp_valid,  dv);
    chk("if_rsp_err",   if_rsp_err,   fv ? m_err : 1'b0);
    chk("d_rsp_err",    d_rsp_err,    dv ? m_err : 1'b0);
    if (!fv || m_dknown) chk("if_rsp_data", if_rsp_data, fv ? m_data : 16'h0000);
    if (!dv || m_dknown) chk("d_rsp_data",  d_rsp_data,  dv ? m_data : 16'h0000);
  endtask

  task automatic m_step();
    if (reset) begin
      m_busy = 0; m_resp = 0; m_last = 0; m_live = 1;
    end else if (m_busy && m_resp) begin
      if (m_owner ? d_rsp_ready : if_rsp_ready) m_busy = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin m_access(); m_resp = 1; end
    end else if (grant_d() || grant_f()) begin
      m_owner = grant_d();
      m_addr  = m_owner ? d_req_addr : if_req_addr;
      m_we    = m_owner && d_req_we;
      m_bsel  = m_owner && d_req_byte;
      m_wdata = d_req_wdata;
      m_last  = m_owner;
      m_busy  = 1;
      m_resp  = 0;
      m_left  = WS;
      if (WS == 0) begin m_access(); m_resp = 1; end
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (m_live) m_compare();
      @(posedge clock);
      m_step();
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a rising edge; returns just after a rising edge.
  task automatic xact(input bit ch, input logic [15:0] addr, input bit we, input bit bsel,
                      input logic [15:0] wd, output logic [15:0] rd, output logic re,
                      output int lat);
    bit ok;
    ok  = 0;
    rd  = 16'hDEAD;
    re  = 1'bx;
    lat = -1;
    if (ch) begin
      d_req_addr = addr; d_req_we = we; d_req_byte = bsel; d_req_wdata = wd; d_req_valid = 1;
    end else begin
      if_req_addr = addr; if_req_valid = 1;
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (ch ? d_req_ready : if_req_ready) begin ok = 1; break; end
    end
    @(posedge clock); #1;
    d_req_valid = 0; if_req_valid = 0;
    // Scramble fields after acceptance: the latched transaction must not change.
    d_req_addr = 16'($urandom); d_req_wdata = 16'($urandom); if_req_addr = 16'($urandom);
    d_req_we = 1'($urandom); d_req_byte = 1'($urandom);
    chk("accept_timeout", ok, 1'b1);
    if (!ok) return;
    for (int k = 1; k < 40; k++) begin
      @(negedge clock);
      if (ch ? d_rsp_valid : if_rsp_valid) begin
        lat = k;
        rd  = ch ? d_rsp_data : if_rsp_data;
        re  = ch ? d_rsp_err : if_rsp_err;
        break;
      end
    end
    chk("response_timeout", lat > 0, 1'b1);
    @(posedge clock); #1;
  endtask

  function automatic logic [15:0] rnd_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 16'h2000 + 16'($urandom_range(0, 255));
    if (r == 1) return 16'hFFFE;
    return 16'($urandom_range(0, 63));
  endfunction

  logic [15:0] rd, fdat;
  logic        re;
  int          lat, n, facc, flat;
  logic [3:0]  order;
  bit          ok;

  initial begin
    reset = 1;
    if_req_valid = 0; if_req_addr = 0; if_rsp_ready = 1;
    d_req_valid = 0; d_req_addr = 0; d_req_we = 0; d_req_byte = 0; d_req_wdata = 0;
    d_rsp_ready = 1;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    chk("rst_if_rsp_valid", if_rsp_valid, 1'b0);
    chk("rst_d_rsp_valid",  d_rsp_valid,  1'b0);
    chk("rst_d_rsp_data",   d_rsp_data,   16'h0000);
    chk("rst_if_rsp_err",   if_rsp_err,   1'b0);

    // Both channels valid continuously out of reset: data write preloads
    // 0x0100 = 0o012701, fetch reads it.
    @(posedge clock); #1;
    d_req_addr = 16'h0100; d_req_we = 1; d_req_byte = 0; d_req_wdata = 16'h15C1; d_req_valid = 1;
    if_req_addr = 16'h0100; if_req_valid = 1;
    @(posedge clock); #1;
    reset = 0;
    n = 0; order = 4'b0; facc = -1; flat = -1; fdat = 16'hDEAD;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clock);
      if (if_rsp_valid && flat < 0 && facc >= 0) begin flat = c - facc; fdat = if_rsp_data; end
      if (d_req_ready) begin order[n] = 1'b1; n++; end
      else if (if_req_ready) begin order[n] = 1'b0; if (facc < 0) facc = c; n++; end
    end
    @(posedge clock); #1;
    d_req_valid = 0; if_req_valid = 0;
    chk("grant_count", n, 4);
    chk("grant_order", order, 4'b0101);
    chk("fetch_latency", flat, 1 + WS);
    chk("fetch_data", fdat, 16'h15C1);
    repeat (6) @(posedge clock);
    #1;

    xact(0, 16'h0100, 0, 0, 0, rd, re, lat);
    chk("fetch2_data", rd, 16'h15C1); chk("fetch2_err", re, 1'b0); chk("fetch2_lat", lat, 1 + WS);

    // Byte lanes
    xact(1, 16'h0200, 1, 0, 16'h1234, rd, re, lat);
    chk("wr_word_rsp", rd, 16'h0000); chk("wr_word_err", re, 1'b0);
    xact(1, 16'h0201, 1, 1, 16'h77AB, rd, re, lat);
    xact(1, 16'h0200, 0, 0, 0, rd, re, lat);
    chk("rd_word_0200", rd, 16'hAB34);
    xact(1, 16'h0200, 0, 1, 0, rd, re, lat);
    chk("rd_byte_0200", rd, 16'h0034);
    xact(1, 16'h0201, 0, 1, 0, rd, re, lat);
    chk("rd_byte_0201", rd, 16'h00AB);

    // Bus errors
    xact(1, 16'h1FFE, 1, 0, 16'h5A5A, rd, re, lat);
    xact(1, 16'h0000, 1, 0, 16'h1111, rd, re, lat);
    xact(1, 16'h0202, 1, 0, 16'h4321, rd, re, lat);
    xact(0, 16'h0101, 0, 0, 0, rd, re, lat);
    chk("odd_fetch_err", re, 1'b1); chk("odd_fetch_data", rd, 16'h0000);
    xact(1, 16'h0203, 0, 0, 0, rd, re, lat);
    chk("odd_read_err", re, 1'b1); chk("odd_read_data", rd, 16'h0000);
    xact(1, 16'h0203, 1, 0, 16'h9999, rd, re, lat);
    chk("odd_write_err", re, 1'b1);
    xact(1, 16'h2000, 1, 0, 16'hFFFF, rd, re, lat);
    chk("oor_write_err", re, 1'b1); chk("oor_write_data", rd, 16'h0000);
    xact(1, 16'h1FFE, 0, 0, 0, rd, re, lat);
    chk("rd_1ffe", rd, 16'h5A5A); chk("rd_1ffe_err", re, 1'b0);
    xact(1, 16'h0000, 0, 0, 0, rd, re, lat);
    chk("rd_0000_after_oor", rd, 16'h1111);
    xact(1, 16'h0202, 0, 0, 0, rd, re, lat);
    chk("rd_0202_after_odd", rd, 16'h4321);

    // Response backpressure
    d_rsp_ready = 0;
    d_req_addr = 16'h0200; d_req_we = 0; d_req_byte = 0; d_req_valid = 1;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin @(negedge clock); ok = d_req_ready; end
    @(posedge clock); #1;
    d_req_valid = 0; if_req_addr = 16'h0100; if_req_valid = 1;
    chk("bp_accept", ok, 1'b1);
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin @(negedge clock); ok = d_rsp_valid; end
    chk("bp_valid", ok, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      @(negedge clock);
      chk("bp_hold_valid", d_rsp_valid, 1'b1);
      chk("bp_hold_data", d_rsp_data, 16'hAB34);
      chk("bp_no_fetch_ready", if_req_ready, 1'b0);
    end
    @(posedge clock); #1;
    d_rsp_ready = 1;
    @(posedge clock); #1;
    @(negedge clock);
    chk("bp_release_ready", if_req_ready, 1'b1);
    @(posedge clock); #1;
    if_req_valid = 0;
    repeat (4) @(posedge clock);
    #1;

    // Reset during WAIT of a write
    xact(1, 16'h0300, 1, 0, 16'h0000, rd, re, lat);
    d_req_addr = 16'h0300; d_req_we = 1; d_req_byte = 0; d_req_wdata = 16'hBEEF; d_req_valid = 1;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin @(negedge clock); ok = d_req_ready; end
    @(posedge clock); #1;
    d_req_valid = 0; reset = 1;
    chk("rw_accept", ok, 1'b1);
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    chk("rw_d_valid", d_rsp_valid, 1'b0);
    chk("rw_d_data", d_rsp_data, 16'h0000);
    chk("rw_d_err", d_rsp_err, 1'b0);
    ok = 0;
    for (int k = 0; k < 5; k++) begin @(negedge clock); if (d_rsp_valid) ok = 1; end
    chk("rw_no_response", ok, 1'b0);
    @(posedge clock); #1;
    xact(1, 16'h0300, 0, 0, 0, rd, re, lat);
    chk("rw_mem_unchanged", rd, 16'h0000);

    // Random traffic; the model checks every cycle.
    for (int c = 0; c < 600; c++) begin
      if_req_valid = ($urandom_range(0, 2) != 0);
      if_req_addr  = rnd_addr();
      d_req_valid  = ($urandom_range(0, 2) != 0);
      d_req_addr   = rnd_addr();
      d_req_we     = 1'($urandom);
      d_req_byte   = 1'($urandom);
      d_req_wdata  = 16'($urandom);
      if_rsp_ready = ($urandom_range(0, 3) != 0);
      d_rsp_ready  = ($urandom_range(0, 3) != 0);
      reset        = ($urandom_range(0, 149) == 0);
      @(posedge clock); #1;
    end
    reset = 0; if_req_valid = 0; d_req_valid = 0; if_rsp_ready = 1; d_rsp_ready = 1;
    repeat (8) @(posedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
